// File: rtl/meas_div_sched_if.sv
// Signal bundle around meas_div_sched: two requesters, the shared divider and the result port.
// slave is the scheduler's view; master is the view of everything around it.
interface meas_div_sched_if #(
  parameter int DW = 32,
  parameter int QW = 32
);
  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_dividend;
  logic [DW-1:0] req0_divisor;

  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_dividend;
  logic [DW-1:0] req1_divisor;

  logic          div_in_valid;
  logic [DW-1:0] div_dividend;
  logic [DW-1:0] div_divisor;
  logic          div_out_valid;
  logic [QW-1:0] div_quotient;

  logic          res_valid;
  logic          res_id;
  logic [QW-1:0] res_data;
  logic          res_err;
  logic          busy;

  modport slave (
    input  req0_valid, req0_dividend, req0_divisor,
    output req0_ready,
    input  req1_valid, req1_dividend, req1_divisor,
    output req1_ready,
    output div_in_valid, div_dividend, div_divisor,
    input  div_out_valid, div_quotient,
    output res_valid, res_id, res_data, res_err, busy
  );

  modport master (
    output req0_valid, req0_dividend, req0_divisor,
    input  req0_ready,
    output req1_valid, req1_dividend, req1_divisor,
    input  req1_ready,
    input  div_in_valid, div_dividend, div_divisor,
    output div_out_valid, div_quotient,
    input  res_valid, res_id, res_data, res_err, busy
  );
endinterface

// File: rtl/meas_div_sched.sv
// Round-robin scheduler sharing one divider between the duty-cycle (port 0) and
// frequency (port 1) measurement paths, with local div-by-zero and a result timeout.
module meas_div_sched #(
  parameter int DW      = 32,
  parameter int QW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_50M,
  input  logic             rst,
  meas_div_sched_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic          last_grant_reg, last_grant_next;
  logic          id_reg, id_next;
  logic [DW-1:0] dividend_reg, dividend_next;
  logic [DW-1:0] divisor_reg, divisor_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [QW-1:0] res_data_reg, res_data_next;
  logic          res_err_reg, res_err_next;
  logic          res_id_reg, res_id_next;

  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic          grant;
  logic          accept;
  logic [DW-1:0] sel_dividend;
  logic [DW-1:0] sel_divisor;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  // On a tie the port that did not win last time goes; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) begin
      grant = ~last_grant_reg;
    end else if (req_valid[1]) begin
      grant = 1'b1;
    end
  end

  assign accept = (state_reg == IDLE) && (|req_valid) && !rst;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grant == 1'(gi));
    end
  endgenerate

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];

  assign sel_dividend = grant ? bus.req1_dividend : bus.req0_dividend;
  assign sel_divisor  = grant ? bus.req1_divisor  : bus.req0_divisor;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    id_next         = id_reg;
    dividend_next   = dividend_reg;
    divisor_next    = divisor_reg;
    cnt_next        = cnt_reg;
    res_data_next   = res_data_reg;
    res_err_next    = res_err_reg;
    res_id_next     = res_id_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          id_next         = grant;
          last_grant_next = grant;
          dividend_next   = sel_dividend;
          divisor_next    = sel_divisor;
          if (sel_divisor == '0) begin
            // Zero divisor never reaches the divider: answer with a saturated error.
            res_id_next   = grant;
            res_data_next = '1;
            res_err_next  = 1'b1;
            state_next    = RESP;
          end else begin
            state_next    = ISSUE;
          end
        end
      end

      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT;
      end

      WAIT: begin
        cnt_next = cnt_reg + CW'(1);
        // A quotient in the last waiting cycle still counts as a real result.
        if (bus.div_out_valid) begin
          res_id_next   = id_reg;
          res_data_next = bus.div_quotient;
          res_err_next  = 1'b0;
          state_next    = RESP;
        end else if (cnt_reg == CW'(TIMEOUT - 2)) begin
          res_id_next   = id_reg;
          res_data_next = '0;
          res_err_next  = 1'b1;
          state_next    = RESP;
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      dividend_reg   <= '0;
      divisor_reg    <= '0;
      cnt_reg        <= '0;
      res_data_reg   <= '0;
      res_err_reg    <= 1'b0;
      res_id_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      id_reg         <= id_next;
      dividend_reg   <= dividend_next;
      divisor_reg    <= divisor_next;
      cnt_reg        <= cnt_next;
      res_data_reg   <= res_data_next;
      res_err_reg    <= res_err_next;
      res_id_reg     <= res_id_next;
    end
  end

  assign bus.div_in_valid = (state_reg == ISSUE);
  assign bus.div_dividend = dividend_reg;
  assign bus.div_divisor  = divisor_reg;
  assign bus.res_valid    = (state_reg == RESP);
  assign bus.res_id       = res_id_reg;
  assign bus.res_data     = res_data_reg;
  assign bus.res_err      = res_err_reg;
  assign bus.busy         = (state_reg != IDLE);

endmodule
